// File: rtl/p4_router_pkg.sv
// Shared tuser field layout and egress demux types for the P4 router ingress/egress paths.
// tuser layout: [3:0] ingress physical port, [7:4] egress port select, upper bits opaque.
package p4_router_pkg;

    localparam int TUSER_WIDTH         = 16;
    localparam int ING_PHYS_PORT_LSB   = 0;
    localparam int ING_PHYS_PORT_WIDTH = 4;
    localparam int EGR_PORT_SEL_LSB    = 4;
    localparam int EGR_PORT_SEL_WIDTH  = 4;

    localparam logic [31:0] DROP_COUNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } egr_state_e;

endpackage

// File: rtl/p4_router_egr_out_reg.sv
// Single-entry egress output register: one beat held with a one-hot destination port, 1-cycle latency.
// free_o is high when empty or when the addressed port accepts this cycle, so full throughput is kept.
module p4_router_egr_out_reg
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_BYTES = 8
) (
    input  logic                    clk_i,
    input  logic                    areset_i,
    input  logic                    load_i,
    input  logic [NUM_PORTS-1:0]    load_oh_i,
    input  logic [DATA_BYTES*8-1:0] tdata_i,
    input  logic [DATA_BYTES-1:0]   tkeep_i,
    input  logic                    tlast_i,
    input  logic [TUSER_WIDTH-1:0]  tuser_i,
    input  logic [NUM_PORTS-1:0]    tready_i,
    output logic                    free_o,
    output logic [NUM_PORTS-1:0]    tvalid_o,
    output logic [DATA_BYTES*8-1:0] tdata_o,
    output logic [DATA_BYTES-1:0]   tkeep_o,
    output logic                    tlast_o,
    output logic [TUSER_WIDTH-1:0]  tuser_o
);

    logic                    vld_q;
    logic [NUM_PORTS-1:0]    oh_q;
    logic [DATA_BYTES*8-1:0] tdata_q;
    logic [DATA_BYTES-1:0]   tkeep_q;
    logic                    tlast_q;
    logic [TUSER_WIDTH-1:0]  tuser_q;

    assign free_o = !vld_q || (|(oh_q & tready_i));

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            vld_q <= 1'b0;
            oh_q  <= '0;
        end else if (free_o) begin
            vld_q <= load_i;
            if (load_i) begin
                oh_q <= load_oh_i;
            end
        end
    end

    // Payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (load_i && free_o) begin
            tdata_q <= tdata_i;
            tkeep_q <= tkeep_i;
            tlast_q <= tlast_i;
            tuser_q <= tuser_i;
        end
    end

    assign tvalid_o = oh_q & {NUM_PORTS{vld_q}};
    assign tdata_o  = tdata_q;
    assign tkeep_o  = tkeep_q;
    assign tlast_o  = tlast_q;
    assign tuser_o  = tuser_q;

endmodule

// File: rtl/p4_router_egr_demux.sv
// Egress demux: steers each packet to the port selected in its SOF tuser, or drops it; 1-cycle latency.
// Input stalls while the held beat's port is not ready; dropped packets are drained at full rate.
module p4_router_egr_demux
    import p4_router_pkg::*;
#(
    parameter int NUM_EGR_PORTS  = 4,
    parameter int DATA_BYTES     = 8,
    parameter int PORT_SEL_LSB   = EGR_PORT_SEL_LSB,
    parameter int PORT_SEL_WIDTH = EGR_PORT_SEL_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     areset_i,
    input  logic                     egr_bus_tvalid_i,
    output logic                     egr_bus_tready_o,
    input  logic [DATA_BYTES*8-1:0]  egr_bus_tdata_i,
    input  logic [DATA_BYTES-1:0]    egr_bus_tkeep_i,
    input  logic                     egr_bus_tlast_i,
    input  logic [TUSER_WIDTH-1:0]   egr_bus_tuser_i,
    output logic [NUM_EGR_PORTS-1:0] egr_ports_tvalid_o,
    input  logic [NUM_EGR_PORTS-1:0] egr_ports_tready_i,
    output logic [DATA_BYTES*8-1:0]  egr_ports_tdata_o,
    output logic [DATA_BYTES-1:0]    egr_ports_tkeep_o,
    output logic                     egr_ports_tlast_o,
    output logic [TUSER_WIDTH-1:0]   egr_ports_tuser_o,
    input  logic [NUM_EGR_PORTS-1:0] port_enable_i,
    input  logic                     drop_clear_i,
    output logic [31:0]              drop_count_o,
    output logic                     drop_pulse_o
);

    generate
        if (NUM_EGR_PORTS < 1 || NUM_EGR_PORTS > 16) begin : g_bad_num_ports
            $error("NUM_EGR_PORTS must be in 1..16");
        end
        if ((2 ** PORT_SEL_WIDTH) < NUM_EGR_PORTS) begin : g_bad_sel_width
            $error("PORT_SEL_WIDTH too narrow to address NUM_EGR_PORTS");
        end
        if (PORT_SEL_LSB + PORT_SEL_WIDTH > TUSER_WIDTH) begin : g_bad_sel_field
            $error("port select field exceeds tuser width");
        end
    endgenerate

    egr_state_e                 state_q, state_d;
    logic [NUM_EGR_PORTS-1:0]   pkt_oh_q, pkt_oh_d;
    logic                       pulse_q;
    logic [31:0]                count_q, count_d;

    logic [PORT_SEL_WIDTH-1:0]  sof_sel;
    logic [NUM_EGR_PORTS-1:0]   sof_oh;
    logic                       sof_fwd;
    logic                       out_free;
    logic                       rdy;
    logic                       in_hs;
    logic                       load;
    logic [NUM_EGR_PORTS-1:0]   load_oh;
    logic                       drop_sof;

    assign sof_sel = egr_bus_tuser_i[PORT_SEL_LSB +: PORT_SEL_WIDTH];

    // An out-of-range select decodes to an all-zero one-hot, which never matches an enable.
    always_comb begin
        sof_oh = '0;
        for (int i = 0; i < NUM_EGR_PORTS; i++) begin
            sof_oh[i] = (sof_sel == PORT_SEL_WIDTH'(i));
        end
    end

    assign sof_fwd = |(sof_oh & port_enable_i);

    always_comb begin
        state_d  = state_q;
        pkt_oh_d = pkt_oh_q;
        rdy      = 1'b0;
        in_hs    = 1'b0;
        load     = 1'b0;
        load_oh  = pkt_oh_q;
        drop_sof = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy   = out_free;
                in_hs = egr_bus_tvalid_i && rdy;
                if (in_hs) begin
                    pkt_oh_d = sof_oh;
                    if (sof_fwd) begin
                        load    = 1'b1;
                        load_oh = sof_oh;
                        if (!egr_bus_tlast_i) state_d = ST_FWD;
                    end else begin
                        drop_sof = 1'b1;
                        if (!egr_bus_tlast_i) state_d = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                rdy   = out_free;
                in_hs = egr_bus_tvalid_i && rdy;
                if (in_hs) begin
                    load = 1'b1;
                    if (egr_bus_tlast_i) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                rdy   = 1'b1;
                in_hs = egr_bus_tvalid_i;
                if (in_hs && egr_bus_tlast_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign egr_bus_tready_o = rdy && !areset_i;

    always_comb begin
        count_d = count_q;
        if (drop_clear_i) begin
            count_d = {31'd0, pulse_q};
        end else if (pulse_q && count_q != DROP_COUNT_MAX) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q  <= ST_IDLE;
            pkt_oh_q <= '0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pkt_oh_q <= pkt_oh_d;
            pulse_q  <= drop_sof;
            count_q  <= count_d;
        end
    end

    assign drop_pulse_o = pulse_q;
    assign drop_count_o = count_q;

    p4_router_egr_out_reg #(
        .NUM_PORTS  (NUM_EGR_PORTS),
        .DATA_BYTES (DATA_BYTES)
    ) u_out_reg (
        .clk_i     (clk_i),
        .areset_i  (areset_i),
        .load_i    (load),
        .load_oh_i (load_oh),
        .tdata_i   (egr_bus_tdata_i),
        .tkeep_i   (egr_bus_tkeep_i),
        .tlast_i   (egr_bus_tlast_i),
        .tuser_i   (egr_bus_tuser_i),
        .tready_i  (egr_ports_tready_i),
        .free_o    (out_free),
        .tvalid_o  (egr_ports_tvalid_o),
        .tdata_o   (egr_ports_tdata_o),
        .tkeep_o   (egr_ports_tkeep_o),
        .tlast_o   (egr_ports_tlast_o),
        .tuser_o   (egr_ports_tuser_o)
    );

endmodule

// File: tb/tb_p4_router_egr_demux.sv
// Bench for p4_router_egr_demux: directed scenarios plus randomized traffic against a packet-level reference model.
module tb_p4_router_egr_demux;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [63:0] in_dat;
    logic [7:0]  in_keep;
    logic        in_last;
    logic [15:0] in_user;
    logic [3:0]  p_vld;
    logic [3:0]  p_rdy = 4'hF;
    logic [63:0] o_dat;
    logic [7:0]  o_keep;
    logic        o_last;
    logic [15:0] o_user;
    logic [3:0]  en;
    logic        clr;
    logic [31:0] cnt;
    logic        pulse;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rdy_mode = 0;
    bit tog = 1'b1;
    int delivered [N];
    int pulses = 0;

    // reference model state
    bit          m_busy, m_fwd, m_ovld, m_pulse;
    int          m_sel, m_oport;
    logic [88:0] m_obeat;
    logic [31:0] m_cnt;

    p4_router_egr_demux #(
        .NUM_EGR_PORTS(N), .DATA_BYTES(8), .PORT_SEL_LSB(4), .PORT_SEL_WIDTH(4)
    ) dut (
        .clk_i(clk), .areset_i(rst),
        .egr_bus_tvalid_i(in_vld), .egr_bus_tready_o(in_rdy),
        .egr_bus_tdata_i(in_dat), .egr_bus_tkeep_i(in_keep),
        .egr_bus_tlast_i(in_last), .egr_bus_tuser_i(in_user),
        .egr_ports_tvalid_o(p_vld), .egr_ports_tready_i(p_rdy),
        .egr_ports_tdata_o(o_dat), .egr_ports_tkeep_o(o_keep),
        .egr_ports_tlast_o(o_last), .egr_ports_tuser_o(o_user),
        .port_enable_i(en), .drop_clear_i(clr),
        .drop_count_o(cnt), .drop_pulse_o(pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Input acceptance as the rules define it: a forwarded beat needs the output slot free
    // (empty or being taken this cycle); a dropped non-SOF beat is always taken.
    function automatic bit m_rdy();
        bit slot_free;
        if (rst) return 1'b0;
        slot_free = !m_ovld || p_rdy[m_oport];
        if (m_busy && !m_fwd) return 1'b1;
        return slot_free;
    endfunction

    always @(posedge clk) begin
        bit ohs, ihs, np;
        int s;
        cyc++;
        if (rst) begin
            m_busy = 0; m_fwd = 0; m_ovld = 0; m_pulse = 0; m_cnt = 0; m_sel = 0; m_oport = 0;
        end else begin
            ohs = m_ovld && p_rdy[m_oport];
            ihs = in_vld && m_rdy();
            np  = 1'b0;
            if (ohs) m_ovld = 0;
            if (ihs) begin
                if (!m_busy) begin
                    s = int'(in_user[7:4]);
                    m_sel = s;
                    m_fwd = (s < N) ? bit'(en[s]) : 1'b0;
                    m_busy = !in_last;
                    np = !m_fwd;
                end else if (in_last) begin
                    m_busy = 0;
                end
                if (m_fwd) begin
                    m_ovld = 1; m_oport = m_sel;
                    m_obeat = {in_dat, in_keep, in_last, in_user};
                end
            end
            if (clr) m_cnt = m_pulse ? 32'd1 : 32'd0;
            else if (m_pulse && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_pulse = np;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_tvalid", p_vld, 0);
            chk("rst_tready", in_rdy, 0);
            chk("rst_count", cnt, 0);
            chk("rst_pulse", pulse, 0);
        end else begin
            chk("tvalid", p_vld, m_ovld ? (4'b0001 << m_oport) : 4'b0000);
            chk("tready", in_rdy, m_rdy());
            if (m_ovld) chk("beat", {o_dat, o_keep, o_last, o_user}, m_obeat);
            chk("drop_pulse", pulse, m_pulse);
            chk("drop_count", cnt, m_cnt);
            for (int p = 0; p < N; p++) if (p_vld[p] && p_rdy[p]) delivered[p]++;
            if (pulse) pulses++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: p_rdy = 4'($urandom);
            2: begin p_rdy = 4'hF; p_rdy[2] = tog; tog = ~tog; end
            default: p_rdy = 4'hF;
        endcase
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [15:0] u);
        int guard = 0;
        bit hs;
        in_vld = 1; in_dat = d; in_keep = k; in_last = l; in_user = u;
        do begin
            @(negedge clk); hs = in_rdy;
            @(posedge clk); #1; guard++;
        end while (!hs && guard < 200);
        tests++;
        if (!hs) begin
            fails++;
            $display("FAIL handshake_timeout: tready low for %0d cycles, expected acceptance", guard);
        end
        in_vld = 0;
    endtask

    task automatic send_pkt(input int sel, input int len, input bit gaps, input bit flip);
        for (int b = 0; b < len; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_vld = 0; @(posedge clk); #1;
            end
            if (flip && b == 1) en = 4'($urandom);
            send_beat({$urandom, $urandom},
                      (b == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF,
                      b == len - 1,
                      {8'($urandom), 4'(sel), 4'($urandom)});
        end
    endtask

    task automatic idle(input int n);
        in_vld = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, d0, d1, d2, d3, p0;
        for (int p = 0; p < N; p++) delivered[p] = 0;
        rst = 1; in_vld = 0; in_dat = '0; in_keep = '0; in_last = 0; in_user = '0;
        en = 4'hF; clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle(2);

        // 3-beat packet to port 2, first beat visible one cycle after its handshake
        d0 = delivered[0] + delivered[1] + delivered[3]; d2 = delivered[2];
        in_vld = 1; in_dat = 64'h1111; in_keep = 8'hFF; in_last = 0; in_user = 16'h0021;
        @(posedge clk); #1;
        in_dat = 64'h2222;
        @(negedge clk);
        chk("s34_first_tvalid", p_vld, 4'b0100);
        chk("s34_first_data", o_dat, 64'h1111);
        @(posedge clk); #1;
        in_dat = 64'h3333; in_last = 1;
        @(posedge clk); #1;
        idle(4);
        chk("s34_port2_beats", delivered[2] - d2, 3);
        chk("s34_other_beats", delivered[0] + delivered[1] + delivered[3] - d0, 0);

        // back-to-back single-beat packets at full rate
        d0 = delivered[0]; d1 = delivered[1]; d3 = delivered[3];
        c0 = cyc;
        send_beat(64'hA0, 8'h0F, 1, 16'h0000);
        send_beat(64'hA1, 8'h0F, 1, 16'h0010);
        send_beat(64'hA2, 8'h0F, 1, 16'h0030);
        send_beat(64'hA3, 8'h0F, 1, 16'h0000);
        chk("s35_cycles", cyc - c0, 4);
        idle(3);
        chk("s35_port0", delivered[0] - d0, 2);
        chk("s35_port1", delivered[1] - d1, 1);
        chk("s35_port3", delivered[3] - d3, 1);

        // out-of-range select, then disabled port
        p0 = pulses;
        send_pkt(5, 2, 0, 0);
        en = 4'b1101;
        send_pkt(1, 3, 0, 0);
        idle(3);
        chk("s36_pulses", pulses - p0, 2);
        chk("s36_count", cnt, 2);
        en = 4'hF;

        // port 2 back-pressure toggling every cycle during an 8-beat packet
        d2 = delivered[2];
        tog = 1; rdy_mode = 2;
        send_pkt(2, 8, 0, 0);
        idle(4);
        rdy_mode = 0;
        idle(2);
        chk("s37_port2_beats", delivered[2] - d2, 8);

        // enable removed mid-packet: current packet completes, next one drops
        d2 = delivered[2];
        for (int b = 0; b < 4; b++) begin
            if (b == 1) en[2] = 1'b0;
            send_beat(64'(b), 8'hFF, b == 3, 16'h0020);
        end
        send_pkt(2, 2, 0, 0);
        idle(3);
        chk("s38_port2_beats", delivered[2] - d2, 4);
        chk("s38_count", cnt, 3);
        en = 4'hF;

        // reset at beat 2 of 4, then clear coinciding with a drop
        send_beat(64'hB0, 8'hFF, 0, 16'h0010);
        send_beat(64'hB1, 8'hFF, 0, 16'h0010);
        rst = 1;
        @(negedge clk);
        chk("s39_rst_tvalid", p_vld, 0);
        chk("s39_rst_count", cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        d0 = delivered[0];
        send_beat(64'hC0, 8'h01, 1, 16'h0000);
        idle(2);
        chk("s39_sof_after_reset", delivered[0] - d0, 1);
        send_beat(64'hD0, 8'h01, 1, 16'h0090);
        idle(2);
        chk("s39_count_before_clear", cnt, 1);
        send_beat(64'hD1, 8'h01, 1, 16'h0090);
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        @(negedge clk);
        chk("s39_clear_with_drop", cnt, 1);
        idle(2);

        // randomized traffic with random back-pressure, enables and clears
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            clr = ($urandom_range(0, 9) == 0);
            send_pkt($urandom_range(0, 7), $urandom_range(1, 5), 1, $urandom_range(0, 3) == 0);
            clr = 0;
        end
        idle(10);
        rdy_mode = 0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
